deskew_image_reader: RTL

//  Streams a finished deskewed 28x28 image out of the shared image BRAM to the SVM classifier core.
//  The deskew stage writes its result at addresses 784..1567; this block is the read side of that region.
//  It issues sequential reads and absorbs the 1-cycle BRAM read latency with a 2-entry skid FIFO.
//  It presents pixels on a valid/ready stream and sustains 1 pixel/clk when the consumer never stalls.

---
 rtl/deskew_image_reader.sv | 68 ++++++
 1 files changed

// File: rtl/deskew_image_reader.sv
// deskew_image_reader: streams the deskewed 28x28 image from BRAM to the classifier (ports: clk, reset, start/ready, BRAM address/in_data/en/we, out_data/out_valid/out_ready/out_last)
module deskew_image_reader #(
  parameter int WIDTH      = 16,
  parameter int BASE_ADDR  = 784,
  parameter int NUM_PIXELS = 784
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  output logic [10:0]      address,
  input  logic [WIDTH-1:0] in_data,
  output logic             en,
  output logic             we,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [9:0] num_px = 10'(NUM_PIXELS);
  localparam logic [9:0] last_px = 10'(NUM_PIXELS - 1);
  localparam logic [10:0] base = 11'(BASE_ADDR);
  state_t state;
  logic [9:0] read_cnt, out_cnt;
  logic [WIDTH-1:0] mem [2];
  logic wr_ptr, rd_ptr, inflight, pop;
  logic [1:0] fifo_cnt;
  assign ready = state == IDLE;
  assign we = 1'b0;
  assign out_valid = fifo_cnt != 2'd0;
  assign pop = out_valid & out_ready;
  assign out_data = mem[rd_ptr];
  assign out_last = out_valid & (out_cnt == last_px);
  assign en = (state == RUN) && (read_cnt < num_px) &&
              (({1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
  assign address = en ? base + {1'b0, read_cnt} : 11'd0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      read_cnt <= '0;
      out_cnt <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      fifo_cnt <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= en;
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
      if (en) read_cnt <= read_cnt + 10'd1;
      if (inflight) begin
        mem[wr_ptr] <= in_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        out_cnt <= out_cnt + 10'd1;
      end
      if (state == IDLE && start) begin
        state <= RUN;
        read_cnt <= '0;
        out_cnt <= '0;
      end else if (pop && out_last) state <= IDLE;
    end
  end
endmodule
